// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM states, ALU control
// codes for the HI/LO arithmetic group and the divide-by-zero quotient.
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // ALU control codes of the HI/LO group; divide sits beside multiply.
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Quotient reported for a zero divisor (architecturally unpredictable).
    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, dividend} left by one,
// trial-subtract the divisor and either keep the difference or restore.
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] dvd_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] dvd_o
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;

    // Trial subtraction one bit wider than the operands; its MSB is the borrow.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rem_o   = '0;
        dvd_o   = '0;
        partial = {rem_i, dvd_i[DATA_W-1]};
        diff    = partial - {1'b0, dvs_i};
        if (!diff[DATA_W]) begin
            rem_o = diff[DATA_W-1:0];
            dvd_o = {dvd_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o = partial[DATA_W-1:0];
            dvd_o = {dvd_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. Operands are reduced to
// magnitudes, divided one bit per cycle, then sign-fixed into {rem, quot}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                signed_div,
    input  logic                annul,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                busy
);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q, dvd_q, dvs_q;
    logic                sign1_q, sign2_q, sdiv_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q, busy_q;

    logic [DATA_W-1:0]   rem_d, dvd_d;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    // Magnitudes are taken only for a signed divide with a negative operand.
    assign abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    assign abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

    // Quotient is negative when signs differ; remainder follows the dividend.
    assign quot_fix = (sdiv_q && (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
    assign rem_fix  = (sdiv_q && sign1_q) ? -rem_q : rem_q;

    div_unit_step #(.DATA_W(DATA_W)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .dvd_o (dvd_d)
    );

    // Control FSM with registered ready/busy/result; annul overrides everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: datapath registers are reset as well so result reads zero out of reset.
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            sdiv_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (annul) begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        if (opdata2 != '0) begin
                            dvd_q   <= abs1;
                            dvs_q   <= abs2;
                            rem_q   <= '0;
                            sign1_q <= opdata1[DATA_W-1];
                            sign2_q <= opdata2[DATA_W-1];
                            sdiv_q  <= signed_div;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= DIV_CALC;
                        end else begin
                            result_q <= {opdata1, {DATA_W{1'b1}}};
                            ready_q  <= 1'b1;
                            state_q  <= DIV_DONE;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    result_q <= {rem_fix, quot_fix};
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= DIV_DONE;
                end
                DIV_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected results computed
// with plain integer arithmetic, a monitor pops them on every ready pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_res = '0;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating division, remainder carries the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every ready pulse must match the oldest pending expectation.
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: got ready=1 with result %h, expected no pending op", result);
                end else begin
                    exp = sb_q.pop_front();
                    check("result", result, exp);
                    check("busy_with_ready", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    // Issue one operation, optionally pulsing a stray start at cycle poke_at.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int poke_at);
        int  cycles;
        int  exp_lat;
        bit  busy_ok;
        exp_lat = (b == 32'd0) ? 1 : 34;
        sb_q.push_back(exp);
        @(negedge clk);
        opdata1 = a;
        opdata2 = b;
        signed_div = sgn;
        start = 1'b1;
        cycles = 0;
        busy_ok = 1'b1;
        while (cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (cycles == poke_at) begin
                start = 1'b1;
                opdata1 = 32'hDEAD_BEEF;
                opdata2 = 32'd0;
            end else begin
                start = 1'b0;
            end
            if (busy !== (cycles < exp_lat)) busy_ok = 1'b0;
            if (ready === 1'b1) break;
        end
        check("latency", 64'(cycles), 64'(exp_lat));
        check("busy_profile", {63'd0, busy_ok}, 64'd1);
        last_res = exp;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        int          mode;

        // Reset state.
        #12;
        check("reset_result", result, 64'd0);
        check("reset_ready_busy", {62'd0, ready, busy}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0);
        do_op(-32'sd100, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0);
        do_op(32'd100, -32'sd7, 1'b1, {32'd2, 32'hFFFF_FFF2}, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 0);
        do_op(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 0);

        // Stray start while busy, and start coincident with ready.
        do_op(32'd1000, 32'd9, 1'b0, {32'd1, 32'd111}, 5);
        do_op(32'd81, 32'd9, 1'b0, {32'd0, 32'd9}, 34);

        // Annul mid-calculation: no ready, result untouched.
        @(negedge clk);
        opdata1 = 32'hFFFF_FFFF;
        opdata2 = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready_busy", {62'd0, ready, busy}, 64'd0);
        check("annul_result_held", result, last_res);
        repeat (40) @(negedge clk);
        check("annul_result_after", result, last_res);

        // Annul together with start in IDLE.
        opdata1 = 32'd7;
        opdata2 = 32'd0;
        start = 1'b1;
        annul = 1'b1;
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        check("annul_start_ready_busy", {62'd0, ready, busy}, 64'd0);
        repeat (3) @(negedge clk);

        do_op(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 0);

        // Asynchronous reset mid-calculation.
        @(negedge clk);
        opdata1 = 32'd12345;
        opdata2 = 32'd17;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_result", result, 64'd0);
        check("async_reset_ready_busy", {62'd0, ready, busy}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_op(32'd12345, 32'd17, 1'b0, ref_div(32'd12345, 32'd17, 1'b0), 0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 7);
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case (mode)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            sgn = 1'($urandom_range(0, 1));
            do_op(a, b, sgn, ref_div(a, b, sgn), 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
